// File: rtl/anabellek_hakem.sv
// ---------------------------------------------------------------------------
// anabellek_hakem
//
// Round-robin arbiter sharing the single main-memory port (iomem valid/ready)
// between the instruction-side L1 controller (l1b, read-only) and the
// data-side L1 controller (l1v, read/write). One request is in flight at a
// time. It is held on iomem until the memory answers or a watchdog expires.
// The granted requester then gets a one-cycle response pulse.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   iomem_valid/ready          memory handshake
//   iomem_wstrb/addr/wdata     registered request fields (wstrb 0 = read)
//   iomem_rdata                memory read data, valid with iomem_ready
//   l1b_istek/kabul/addr       instruction-side request, accept, read address
//   l1b_yanit                  instruction-side response pulse
//   l1v_istek/kabul/addr/      data-side request, accept, address,
//   l1v_wdata/wstrb            write data, byte enables (0 = read)
//   l1v_yanit                  data-side response pulse
//   yanit_rdata/yanit_hata     shared response data / timeout flag,
//                              qualified by l1b_yanit or l1v_yanit
//   mesgul                     high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module anabellek_hakem #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  input  logic        l1b_istek,
  output logic        l1b_kabul,
  input  logic [31:0] l1b_addr,
  output logic        l1b_yanit,
  input  logic        l1v_istek,
  output logic        l1v_kabul,
  input  logic [31:0] l1v_addr,
  input  logic [31:0] l1v_wdata,
  input  logic [3:0]  l1v_wstrb,
  output logic        l1v_yanit,
  output logic [31:0] yanit_rdata,
  output logic        yanit_hata,
  output logic        mesgul
);

  // The counter only has to reach TIMEOUT_CYCLES-1, so this width always fits.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q;    // preferred requester: 0 = l1b, 1 = l1v
  logic          grant_q;  // requester being served: 0 = l1b, 1 = l1v
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          hata_q;

  logic any_req;
  logic pick_v;
  logic timeout;

  // l1v wins when it is the only requester, or when both ask and the
  // pointer prefers it.
  assign any_req = l1b_istek | l1v_istek;
  assign pick_v  = l1v_istek & (~l1b_istek | ptr_q);
  assign timeout = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BOSTA;
    else         state_q <= state_d;
  end

  // Next state and the combinational accept. kabul is gated with rst_ni so
  // that nothing is accepted while reset is held, even though the state
  // register already reads BOSTA.
  always_comb begin
    state_d   = state_q;
    l1b_kabul = 1'b0;
    l1v_kabul = 1'b0;
    case (state_q)
      BOSTA: begin
        if (any_req) begin
          state_d   = ISTEK;
          l1b_kabul = rst_ni & ~pick_v;
          l1v_kabul = rst_ni & pick_v;
        end
      end
      ISTEK: begin
        if (iomem_ready || timeout) state_d = YANIT;
      end
      YANIT:   state_d = BOSTA;
      default: state_d = BOSTA;
    endcase
  end

  // Request capture, watchdog, response capture and pointer update.
  // Ready is tested before the watchdog so a late answer on the final
  // cycle is still delivered as a normal response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      case (state_q)
        BOSTA: begin
          if (any_req) begin
            grant_q <= pick_v;
            cnt_q   <= '0;
            addr_q  <= pick_v ? l1v_addr  : l1b_addr;
            wdata_q <= pick_v ? l1v_wdata : 32'h0;
            wstrb_q <= pick_v ? l1v_wstrb : 4'h0;
          end
        end
        ISTEK: begin
          cnt_q <= cnt_q + 1'b1;
          if (iomem_ready) begin
            rdata_q <= (wstrb_q == 4'h0) ? iomem_rdata : 32'h0;
            hata_q  <= 1'b0;
          end else if (timeout) begin
            rdata_q <= 32'h0;
            hata_q  <= 1'b1;
          end
        end
        YANIT: begin
          ptr_q <= ~grant_q;
        end
        default: ;
      endcase
    end
  end

  assign iomem_valid = (state_q == ISTEK);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign l1b_yanit   = (state_q == YANIT) & ~grant_q;
  assign l1v_yanit   = (state_q == YANIT) &  grant_q;
  assign yanit_rdata = rdata_q;
  assign yanit_hata  = hata_q;
  assign mesgul      = (state_q != BOSTA);

endmodule

// File: tb/tb_anabellek_hakem.sv
// ---------------------------------------------------------------------------
// tb_anabellek_hakem
//
// Directed bench for the iomem round-robin arbiter, built with an 8-cycle
// watchdog. Inputs change 1 ns after the rising edge and outputs are
// sampled 1 ns after that, away from the active edge. The memory side is
// driven directly by the directed steps.
// ---------------------------------------------------------------------------
module tb_anabellek_hakem;

  localparam int unsigned TO = 8;

  logic        clk_i;
  logic        rst_ni;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        l1b_istek;
  logic        l1b_kabul;
  logic [31:0] l1b_addr;
  logic        l1b_yanit;
  logic        l1v_istek;
  logic        l1v_kabul;
  logic [31:0] l1v_addr;
  logic [31:0] l1v_wdata;
  logic [3:0]  l1v_wstrb;
  logic        l1v_yanit;
  logic [31:0] yanit_rdata;
  logic        yanit_hata;
  logic        mesgul;

  int checks = 0;
  int errors = 0;

  anabellek_hakem #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .l1b_istek   (l1b_istek),
    .l1b_kabul   (l1b_kabul),
    .l1b_addr    (l1b_addr),
    .l1b_yanit   (l1b_yanit),
    .l1v_istek   (l1v_istek),
    .l1v_kabul   (l1v_kabul),
    .l1v_addr    (l1v_addr),
    .l1v_wdata   (l1v_wdata),
    .l1v_wstrb   (l1v_wstrb),
    .l1v_yanit   (l1v_yanit),
    .yanit_rdata (yanit_rdata),
    .yanit_hata  (yanit_hata),
    .mesgul      (mesgul)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive both requester ports; settle 1 ns so combinational kabul is valid.
  task automatic applyStimulus(input logic b_req, input logic [31:0] b_addr,
                               input logic v_req, input logic [31:0] v_addr,
                               input logic [31:0] v_wdata, input logic [3:0] v_wstrb);
    l1b_istek = b_req;
    l1b_addr  = b_addr;
    l1v_istek = v_req;
    l1v_addr  = v_addr;
    l1v_wdata = v_wdata;
    l1v_wstrb = v_wstrb;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response outputs for a cycle with no pulse expected.
  task automatic checkIdleResp(input string tag);
    checkOutput({tag, "_b_yanit"}, {31'h0, l1b_yanit}, 32'h0);
    checkOutput({tag, "_v_yanit"}, {31'h0, l1v_yanit}, 32'h0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    l1b_istek   = 1'b0;
    l1b_addr    = 32'h0;
    l1v_istek   = 1'b0;
    l1v_addr    = 32'h0;
    l1v_wdata   = 32'h0;
    l1v_wstrb   = 4'h0;

    // ---- Reset values, with a request pending: kabul must stay low ----
    #2;
    applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'h0, 32'h0, 4'h0);
    checkOutput("rst_valid",  {31'h0, iomem_valid}, 32'h0);
    checkOutput("rst_wstrb",  {28'h0, iomem_wstrb}, 32'h0);
    checkOutput("rst_addr",   iomem_addr,  32'h0);
    checkOutput("rst_wdata",  iomem_wdata, 32'h0);
    checkOutput("rst_bkabul", {31'h0, l1b_kabul}, 32'h0);
    checkOutput("rst_vkabul", {31'h0, l1v_kabul}, 32'h0);
    checkIdleResp("rst");
    checkOutput("rst_rdata",  yanit_rdata, 32'h0);
    checkOutput("rst_hata",   {31'h0, yanit_hata}, 32'h0);
    checkOutput("rst_mesgul", {31'h0, mesgul}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // ---- Single l1b read, ready 3 cycles after valid ----
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rd_bkabul", {31'h0, l1b_kabul}, 32'h1);
    checkOutput("rd_vkabul", {31'h0, l1v_kabul}, 32'h0);
    step();                                            // T+1
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rd_valid",  {31'h0, iomem_valid}, 32'h1);
    checkOutput("rd_addr",   iomem_addr, 32'h0000_0100);
    checkOutput("rd_wstrb",  {28'h0, iomem_wstrb}, 32'h0);
    checkOutput("rd_wdata",  iomem_wdata, 32'h0);
    checkOutput("rd_mesgul", {31'h0, mesgul}, 32'h1);
    step();                                            // T+2
    checkIdleResp("rd_t2");
    step();                                            // T+3
    checkOutput("rd_valid3", {31'h0, iomem_valid}, 32'h1);
    step();                                            // T+4
    iomem_ready = 1'b1;
    iomem_rdata = 32'hDEAD_BEEF;
    step();                                            // T+5
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    checkOutput("rd_byanit", {31'h0, l1b_yanit}, 32'h1);
    checkOutput("rd_vyanit", {31'h0, l1v_yanit}, 32'h0);
    checkOutput("rd_rdata",  yanit_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_hata",   {31'h0, yanit_hata}, 32'h0);
    checkOutput("rd_valid5", {31'h0, iomem_valid}, 32'h0);
    step();                                            // T+6
    checkIdleResp("rd_t6");
    checkOutput("rd_mesgul6", {31'h0, mesgul}, 32'h0);

    // ---- l1v write, immediate ready; memory data must not leak back ----
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011);
    checkOutput("wr_vkabul", {31'h0, l1v_kabul}, 32'h1);
    checkOutput("wr_bkabul", {31'h0, l1b_kabul}, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr_valid", {31'h0, iomem_valid}, 32'h1);
    checkOutput("wr_addr",  iomem_addr, 32'h2000_0004);
    checkOutput("wr_wdata", iomem_wdata, 32'h1234_5678);
    checkOutput("wr_wstrb", {28'h0, iomem_wstrb}, 32'h3);
    iomem_ready = 1'b1;
    iomem_rdata = 32'hFFFF_FFFF;
    step();
    iomem_ready = 1'b0;
    checkOutput("wr_vyanit", {31'h0, l1v_yanit}, 32'h1);
    checkOutput("wr_byanit", {31'h0, l1b_yanit}, 32'h0);
    checkOutput("wr_rdata",  yanit_rdata, 32'h0);
    checkOutput("wr_hata",   {31'h0, yanit_hata}, 32'h0);
    checkOutput("wr_keep_addr", iomem_addr, 32'h2000_0004);
    step();

    // ---- Reset, then both requesters held high, zero-wait memory ----
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
    iomem_ready = 1'b1;
    applyStimulus(1'b1, 32'h0000_0B00, 1'b1, 32'h0000_0C00, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      logic exp_v;
      exp_v = (i % 2 == 1);
      iomem_rdata = 32'hA000_0000 + i;
      checkOutput($sformatf("rr%0d_bkabul", i), {31'h0, l1b_kabul}, {31'h0, ~exp_v});
      checkOutput($sformatf("rr%0d_vkabul", i), {31'h0, l1v_kabul}, {31'h0, exp_v});
      step();
      checkOutput($sformatf("rr%0d_addr", i), iomem_addr,
                  exp_v ? 32'h0000_0C00 : 32'h0000_0B00);
      step();
      checkOutput($sformatf("rr%0d_byanit", i), {31'h0, l1b_yanit}, {31'h0, ~exp_v});
      checkOutput($sformatf("rr%0d_vyanit", i), {31'h0, l1v_yanit}, {31'h0, exp_v});
      checkOutput($sformatf("rr%0d_rdata", i), yanit_rdata, 32'hA000_0000 + i);
      checkOutput($sformatf("rr%0d_nokabul", i), {30'h0, l1b_kabul, l1v_kabul}, 32'h0);
      step();
    end
    iomem_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

    // ---- Timeout: valid high exactly TO cycles, then hata response ----
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    checkOutput("to_vkabul", {31'h0, l1v_kabul}, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    iomem_rdata = 32'h7777_7777;
    for (int c = 0; c < int'(TO); c++) begin
      checkOutput($sformatf("to_valid%0d", c), {31'h0, iomem_valid}, 32'h1);
      checkIdleResp($sformatf("to_c%0d", c));
      step();
    end
    checkOutput("to_valid_end", {31'h0, iomem_valid}, 32'h0);
    checkOutput("to_vyanit",    {31'h0, l1v_yanit}, 32'h1);
    checkOutput("to_hata",      {31'h0, yanit_hata}, 32'h1);
    checkOutput("to_rdata",     yanit_rdata, 32'h0);
    step();

    // Next request after the timeout completes normally.
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("after_bkabul", {31'h0, l1b_kabul}, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    iomem_ready = 1'b1;
    iomem_rdata = 32'h0000_55AA;
    step();
    iomem_ready = 1'b0;
    checkOutput("after_byanit", {31'h0, l1b_yanit}, 32'h1);
    checkOutput("after_hata",   {31'h0, yanit_hata}, 32'h0);
    checkOutput("after_rdata",  yanit_rdata, 32'h0000_55AA);
    step();

    // ---- Ready on the final watchdog cycle: ready wins ----
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0500, 32'h0, 4'h0);
    checkOutput("late_vkabul", {31'h0, l1v_kabul}, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < int'(TO) - 1; c++) step();
    checkOutput("late_valid", {31'h0, iomem_valid}, 32'h1);
    iomem_ready = 1'b1;
    iomem_rdata = 32'hCAFE_F00D;
    step();
    iomem_ready = 1'b0;
    checkOutput("late_vyanit", {31'h0, l1v_yanit}, 32'h1);
    checkOutput("late_hata",   {31'h0, yanit_hata}, 32'h0);
    checkOutput("late_rdata",  yanit_rdata, 32'hCAFE_F00D);
    step();

    // ---- Reset during ISTEK: valid drops at once, no response follows ----
    applyStimulus(1'b1, 32'h0000_0600, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("mid_bkabul", {31'h0, l1b_kabul}, 32'h1);
    step();
    checkOutput("mid_valid", {31'h0, iomem_valid}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_valid_rst", {31'h0, iomem_valid}, 32'h0);
    checkOutput("mid_mesgul",    {31'h0, mesgul}, 32'h0);
    checkOutput("mid_kabul",     {31'h0, l1b_kabul}, 32'h0);
    checkOutput("mid_addr",      iomem_addr, 32'h0);
    step();
    checkIdleResp("mid_rst1");
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkIdleResp($sformatf("mid_post%0d", c));
    end

    // l1v alone after release is served first.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0700, 32'h0, 4'h0);
    checkOutput("post_vkabul", {31'h0, l1v_kabul}, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    iomem_ready = 1'b1;
    iomem_rdata = 32'h0BAD_CAFE;
    step();
    iomem_ready = 1'b0;
    checkOutput("post_vyanit", {31'h0, l1v_yanit}, 32'h1);
    checkOutput("post_rdata",  yanit_rdata, 32'h0BAD_CAFE);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
